z80_io_regfile_p: RTL and testbench

Parametrised Z80 I/O register file that succeeds the fixed 80h–A3h map. It decodes Z80 I/O cycles at `BASE_ADR`, and each bus cycle triggers exactly one action. It provides an auto-incrementing RAM pointer with a data port and a non-incrementing peek port. It also provides N writable control bytes with readback, and M status bytes with an atomic snapshot. It sits between the CPU bus and the executor RAM/control logic; the top level builds the `d_cpu` tristate from `d_out`/`d_oe`.

---
 rtl/z80_io_pkg.sv | 17 +
 rtl/z80_io_regfile_p_access_fsm.sv | 53 +++++
 rtl/z80_io_regfile_p.sv | 155 +++++++++++++++
 tb/tb_z80_io_regfile_p.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_io_pkg.sv
// Shared constants, FSM state type and parameter range checks for the Z80 I/O register file.
package z80_io_pkg;

  localparam int unsigned OFS_DATA = 32'h00;
  localparam int unsigned OFS_PTR  = 32'h01;
  localparam int unsigned OFS_PEEK = 32'h0F;
  localparam int unsigned OFS_CTRL = 32'h10;
  localparam int unsigned OFS_STAT = 32'h40;

  typedef enum logic [1:0] {StIdle, StAct, StHold} io_state_e;

  function automatic bit cfg_ok(int unsigned n_ctrl, int unsigned n_stat, int unsigned ptr_w);
    return (n_ctrl >= 1) && (n_ctrl <= 48) && (n_stat >= 1) && (n_stat <= 64) &&
           (ptr_w >= 8) && (ptr_w <= 32) && ((ptr_w % 8) == 0);
  endfunction

endpackage

// File: rtl/z80_io_regfile_p_access_fsm.sv
// Z80 I/O strobe decode and IDLE/ACT/HOLD access sequencer: one action pulse per bus cycle.
module z80_io_access_fsm
  import z80_io_pkg::*;
(
  input  logic clk_cpu,
  input  logic reset_cpu,
  input  logic io_req_cpu,
  input  logic rd_cpu,
  input  logic wr_cpu,
  input  logic m1_cpu,
  output logic act_rd,
  output logic act_wr,
  output logic bus_busy
);

  io_state_e state_q;

  // Reset lands in HOLD so a strobe still low after reset is never taken as a new access.
  always_ff @(posedge clk_cpu or posedge reset_cpu) begin
    if (reset_cpu) begin
      state_q  <= StHold;
      act_rd   <= 1'b0;
      act_wr   <= 1'b0;
      bus_busy <= 1'b1;
    end else begin
      act_rd <= 1'b0;
      act_wr <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!io_req_cpu && m1_cpu && (!rd_cpu || !wr_cpu)) begin
            bus_busy <= 1'b1;
            if (!rd_cpu && !wr_cpu) begin
              state_q <= StHold;
            end else begin
              state_q <= StAct;
              act_rd  <= !rd_cpu;
              act_wr  <= !wr_cpu;
            end
          end
        end
        StAct: state_q <= StHold;
        StHold: begin
          if (io_req_cpu || (rd_cpu && wr_cpu)) begin
            state_q  <= StIdle;
            bus_busy <= 1'b0;
          end
        end
        default: state_q <= StHold;
      endcase
    end
  end

endmodule

// File: rtl/z80_io_regfile_p.sv
// Parametrised Z80 I/O register file: RAM pointer with data/peek ports, control bytes and
// snapshotted status bytes, decoded relative to BASE_ADR.
module z80_io_regfile_p
  import z80_io_pkg::*;
#(
  parameter logic [7:0]          BASE_ADR = 8'h80,
  parameter int unsigned         N_CTRL   = 8,
  parameter int unsigned         N_STAT   = 32,
  parameter int unsigned         PTR_W    = 24,
  parameter logic [N_CTRL*8-1:0] CTRL_RST = '1
) (
  input  logic                clk_cpu,
  input  logic                reset_cpu,
  input  logic [7:0]          a_cpu,
  input  logic [7:0]          d_in,
  output logic [7:0]          d_out,
  output logic                d_oe,
  input  logic                io_req_cpu,
  input  logic                rd_cpu,
  input  logic                wr_cpu,
  input  logic                m1_cpu,
  output logic [N_CTRL*8-1:0] ctrl_out,
  input  logic [N_STAT*8-1:0] status_in,
  output logic [PTR_W-1:0]    ram_addr,
  output logic [7:0]          ram_wdata,
  input  logic [7:0]          ram_rdata,
  output logic                ram_we,
  output logic                ram_re
);

  if (!cfg_ok(N_CTRL, N_STAT, PTR_W)) begin : gen_cfg_err
    $error("z80_io_regfile_p: N_CTRL, N_STAT or PTR_W out of range");
  end

  logic act_rd, act_wr, bus_busy;

  z80_io_access_fsm u_fsm (
    .clk_cpu    (clk_cpu),
    .reset_cpu  (reset_cpu),
    .io_req_cpu (io_req_cpu),
    .rd_cpu     (rd_cpu),
    .wr_cpu     (wr_cpu),
    .m1_cpu     (m1_cpu),
    .act_rd     (act_rd),
    .act_wr     (act_wr),
    .bus_busy   (bus_busy)
  );

  logic [7:0]          ofs8;
  logic [31:0]         ofs;
  logic [PTR_W-1:0]    ptr_q;
  logic [N_CTRL*8-1:0] ctrl_q;
  logic [N_STAT*8-1:0] shadow_q;
  logic [7:0]          d_out_q, ram_wdata_q;
  logic                rd_valid_q, ram_we_q, ram_re_q;
  logic                is_data, is_snap, rd_hit;
  logic [7:0]          rd_byte;

  assign ofs8    = a_cpu - BASE_ADR;
  assign ofs     = {24'd0, ofs8};
  assign is_data = (ofs == OFS_DATA);
  assign is_snap = (ofs == OFS_STAT);

  always_comb begin
    rd_hit  = 1'b0;
    rd_byte = 8'h00;
    if (is_data || (ofs == OFS_PEEK)) begin
      rd_hit  = 1'b1;
      rd_byte = ram_rdata;
    end
    for (int b = 0; b < PTR_W / 8; b++) begin
      if (ofs == OFS_PTR + b) begin
        rd_hit  = 1'b1;
        rd_byte = ptr_q[8*b +: 8];
      end
    end
    for (int k = 0; k < N_CTRL; k++) begin
      if (ofs == OFS_CTRL + k) begin
        rd_hit  = 1'b1;
        rd_byte = ctrl_q[8*k +: 8];
      end
    end
    // Byte 0 comes from the live input because the shadow is loaded by this same read.
    if (is_snap) begin
      rd_hit  = 1'b1;
      rd_byte = status_in[7:0];
    end
    for (int j = 1; j < N_STAT; j++) begin
      if (ofs == OFS_STAT + j) begin
        rd_hit  = 1'b1;
        rd_byte = shadow_q[8*j +: 8];
      end
    end
  end

  always_ff @(posedge clk_cpu or posedge reset_cpu) begin
    if (reset_cpu) begin
      ptr_q       <= '0;
      ctrl_q      <= CTRL_RST;
      shadow_q    <= '0;
      d_out_q     <= 8'h00;
      rd_valid_q  <= 1'b0;
      ram_wdata_q <= 8'h00;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;
      ram_re_q <= 1'b0;
      // Post-increment on the edge that ends the RAM pulse.
      if (ram_we_q || ram_re_q) begin
        ptr_q <= ptr_q + PTR_W'(1);
      end
      if (!bus_busy) begin
        rd_valid_q <= 1'b0;
      end
      if (act_rd) begin
        rd_valid_q <= rd_hit;
        if (rd_hit) begin
          d_out_q <= rd_byte;
        end
        if (is_data) begin
          ram_re_q <= 1'b1;
        end
        if (is_snap) begin
          shadow_q <= status_in;
        end
      end
      if (act_wr) begin
        if (is_data) begin
          ram_wdata_q <= d_in;
          ram_we_q    <= 1'b1;
        end
        for (int b = 0; b < PTR_W / 8; b++) begin
          if (ofs == OFS_PTR + b) begin
            ptr_q[8*b +: 8] <= d_in;
          end
        end
        for (int k = 0; k < N_CTRL; k++) begin
          if (ofs == OFS_CTRL + k) begin
            ctrl_q[8*k +: 8] <= d_in;
          end
        end
      end
    end
  end

  assign d_out     = d_out_q;
  assign d_oe      = rd_valid_q && bus_busy;
  assign ctrl_out  = ctrl_q;
  assign ram_addr  = ptr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign ram_re    = ram_re_q;

endmodule

// File: tb/tb_z80_io_regfile_p.sv
// Randomised self-checking bench for z80_io_regfile_p against a byte-level register map model.
module tb_z80_io_regfile_p;

  logic        clk_cpu = 1'b0;
  logic        reset_cpu = 1'b1;
  logic [7:0]  a_cpu = 8'h00, d_in = 8'h00;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        io_req_cpu = 1'b1, rd_cpu = 1'b1, wr_cpu = 1'b1, m1_cpu = 1'b1;
  logic [63:0] ctrl_out;
  logic [31:0] status_in = 32'h0;
  logic [23:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        ram_we, ram_re;

  z80_io_regfile_p #(
    .BASE_ADR (8'h80),
    .N_CTRL   (8),
    .N_STAT   (4),
    .PTR_W    (24)
  ) dut (
    .clk_cpu    (clk_cpu),
    .reset_cpu  (reset_cpu),
    .a_cpu      (a_cpu),
    .d_in       (d_in),
    .d_out      (d_out),
    .d_oe       (d_oe),
    .io_req_cpu (io_req_cpu),
    .rd_cpu     (rd_cpu),
    .wr_cpu     (wr_cpu),
    .m1_cpu     (m1_cpu),
    .ctrl_out   (ctrl_out),
    .status_in  (status_in),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_we     (ram_we),
    .ram_re     (ram_re)
  );

  always #5 clk_cpu = ~clk_cpu;

  // Reference state
  logic [23:0] m_ptr;
  logic [63:0] m_ctrl;
  logic [31:0] m_shadow;
  logic [7:0]  rd_seed = 8'h00;

  int n_checks = 0;
  int n_errors = 0;
  int re_cnt = 0;
  logic [23:0] we_addr_q[$];
  logic [7:0]  we_data_q[$];

  function automatic logic [7:0] ram_model(input logic [23:0] a);
    return rd_seed ^ a[7:0] ^ a[23:16];
  endfunction

  always_comb ram_rdata = ram_model(ram_addr);

  always @(negedge clk_cpu) begin
    if (ram_we) begin
      we_addr_q.push_back(ram_addr);
      we_data_q.push_back(ram_wdata);
    end
    if (ram_re) re_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr    = 24'h0;
    m_ctrl   = '1;
    m_shadow = 32'h0;
  endtask

  task automatic io_cycle(input bit is_wr, input logic [7:0] adr, input logic [7:0] dat,
                          input int waits, output logic [7:0] rdat, output logic oe_n2,
                          output logic oe_hold, output logic oe_after, output logic we_n2,
                          output logic re_n2);
    @(negedge clk_cpu);
    a_cpu = adr;
    d_in = dat;
    io_req_cpu = 1'b0;
    if (is_wr) wr_cpu = 1'b0;
    else rd_cpu = 1'b0;
    @(negedge clk_cpu);
    @(negedge clk_cpu);
    oe_n2 = d_oe;
    we_n2 = ram_we;
    re_n2 = ram_re;
    repeat (1 + waits) @(negedge clk_cpu);
    rdat = d_out;
    oe_hold = d_oe;
    io_req_cpu = 1'b1;
    rd_cpu = 1'b1;
    wr_cpu = 1'b1;
    @(negedge clk_cpu);
    oe_after = d_oe;
    @(negedge clk_cpu);
  endtask

  task automatic do_access(input bit is_wr, input logic [7:0] adr, input logic [7:0] dat,
                           input int waits);
    int o;
    int we0, re0;
    logic exp_oe, exp_we, exp_re;
    logic [7:0] exp_d, rdat;
    logic oe_n2, oe_hold, oe_after, we_n2, re_n2;
    o = int'(8'(adr - 8'h80));
    exp_oe = 1'b0; exp_we = 1'b0; exp_re = 1'b0; exp_d = 8'h00;
    if (is_wr) begin
      exp_we = (o == 0);
    end else if (o == 0 || o == 15) begin
      exp_oe = 1'b1; exp_d = ram_model(m_ptr); exp_re = (o == 0);
    end else if (o >= 1 && o <= 3) begin
      exp_oe = 1'b1; exp_d = m_ptr[8*(o-1) +: 8];
    end else if (o >= 16 && o <= 23) begin
      exp_oe = 1'b1; exp_d = m_ctrl[8*(o-16) +: 8];
    end else if (o == 64) begin
      exp_oe = 1'b1; exp_d = status_in[7:0];
    end else if (o >= 65 && o <= 67) begin
      exp_oe = 1'b1; exp_d = m_shadow[8*(o-64) +: 8];
    end
    we0 = we_addr_q.size();
    re0 = re_cnt;
    io_cycle(is_wr, adr, dat, waits, rdat, oe_n2, oe_hold, oe_after, we_n2, re_n2);
    check("oe_early", oe_n2, exp_oe);
    check("oe_hold", oe_hold, exp_oe);
    if (exp_oe) check("rd_data", rdat, exp_d);
    check("oe_release", oe_after, 1'b0);
    check("we_pulse", we_n2, exp_we);
    check("re_pulse", re_n2, exp_re);
    check("we_count", we_addr_q.size() - we0, exp_we);
    check("re_count", re_cnt - re0, exp_re);
    if (exp_we && we_addr_q.size() > we0) begin
      check("we_addr", we_addr_q[we0], m_ptr);
      check("we_data", we_data_q[we0], dat);
    end
    if (o == 0) m_ptr = m_ptr + 24'd1;
    if (is_wr && o >= 1 && o <= 3) m_ptr[8*(o-1) +: 8] = dat;
    if (is_wr && o >= 16 && o <= 23) m_ctrl[8*(o-16) +: 8] = dat;
    if (!is_wr && o == 64) m_shadow = status_in;
    check("ram_addr", ram_addr, m_ptr);
    check("ctrl_out", ctrl_out, m_ctrl);
  endtask

  // Drives an abnormal strobe pattern that must leave every register untouched.
  task automatic no_action(input string tag, input logic m1, input logic rd, input logic wr);
    int we0, re0;
    we0 = we_addr_q.size();
    re0 = re_cnt;
    @(negedge clk_cpu);
    a_cpu = 8'h80; d_in = 8'h77;
    io_req_cpu = 1'b0; m1_cpu = m1; rd_cpu = rd; wr_cpu = wr;
    repeat (4) @(negedge clk_cpu);
    check({tag, "_oe"}, d_oe, 1'b0);
    io_req_cpu = 1'b1; m1_cpu = 1'b1; rd_cpu = 1'b1; wr_cpu = 1'b1;
    repeat (2) @(negedge clk_cpu);
    check({tag, "_we"}, we_addr_q.size() - we0, 0);
    check({tag, "_re"}, re_cnt - re0, 0);
    check({tag, "_ptr"}, ram_addr, m_ptr);
    check({tag, "_ctrl"}, ctrl_out, m_ctrl);
  endtask

  logic [7:0] hot_adr[22] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h8F, 8'h90, 8'h91, 8'h93,
                             8'h97, 8'h98, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'h7F,
                             8'hFF, 8'h00, 8'h80, 8'h8E};

  initial begin
    int we0;
    model_reset();
    repeat (3) @(negedge clk_cpu);
    check("rst_ctrl", ctrl_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_addr", ram_addr, 24'h0);
    check("rst_oe", d_oe, 1'b0);
    check("rst_dout", d_out, 8'h00);
    check("rst_we", ram_we, 1'b0);
    check("rst_re", ram_re, 1'b0);
    check("rst_wdata", ram_wdata, 8'h00);
    reset_cpu = 1'b0;
    @(negedge clk_cpu);

    // Pointer load and data-port writes
    do_access(1'b1, 8'h81, 8'h12, 0);
    do_access(1'b1, 8'h82, 8'h34, 0);
    do_access(1'b1, 8'h83, 8'h56, 0);
    do_access(1'b1, 8'h80, 8'hAA, 0);
    do_access(1'b1, 8'h80, 8'hBB, 1);
    check("ptr_563414", ram_addr, 24'h563414);

    // Wrap and peek
    for (int i = 1; i <= 3; i++) do_access(1'b1, 8'(8'h80 + i), 8'hFF, 0);
    rd_seed = 8'h5A;
    do_access(1'b0, 8'h80, 8'h00, 0);
    check("ptr_wrap", ram_addr, 24'h000000);
    do_access(1'b0, 8'h8F, 8'h00, 2);

    // Control bytes and unmapped addresses
    do_access(1'b1, 8'h90, 8'h81, 0);
    do_access(1'b0, 8'h90, 8'h00, 0);
    check("ctrl0", ctrl_out[7:0], 8'h81);
    do_access(1'b1, 8'h7F, 8'h3C, 0);
    do_access(1'b1, 8'hC5, 8'h3C, 0);
    do_access(1'b0, 8'hC5, 8'h00, 0);

    // Status snapshot
    status_in = 32'h1122_3344;
    do_access(1'b0, 8'hC0, 8'h00, 0);
    status_in = 32'hFFFF_FFFF;
    for (int j = 1; j <= 3; j++) do_access(1'b0, 8'(8'hC0 + j), 8'h00, 0);
    check("shadow", m_shadow, 32'h1122_3344);

    // Wait states, illegal strobes, interrupt acknowledge
    do_access(1'b0, 8'h80, 8'h00, 3);
    no_action("both_low", 1'b1, 1'b0, 1'b0);
    no_action("int_ack", 1'b0, 1'b1, 1'b0);
    do_access(1'b1, 8'h80, 8'h66, 0);

    // Reset during ACT of a data write
    do_access(1'b1, 8'h82, 8'h9C, 0);
    we0 = we_addr_q.size();
    @(negedge clk_cpu);
    a_cpu = 8'h80; d_in = 8'hC3; io_req_cpu = 1'b0; wr_cpu = 1'b0;
    @(posedge clk_cpu);
    #2 reset_cpu = 1'b1;
    repeat (2) @(negedge clk_cpu);
    reset_cpu = 1'b0;
    model_reset();
    check("rstact_addr", ram_addr, 24'h0);
    check("rstact_ctrl", ctrl_out, m_ctrl);
    repeat (4) @(negedge clk_cpu);
    check("rstact_we", we_addr_q.size() - we0, 0);
    check("rstact_hold_addr", ram_addr, 24'h0);
    io_req_cpu = 1'b1; wr_cpu = 1'b1;
    repeat (2) @(negedge clk_cpu);
    do_access(1'b0, 8'hC1, 8'h00, 0);
    do_access(1'b1, 8'h80, 8'hDD, 0);

    // Randomised traffic
    for (int n = 0; n < 250; n++) begin
      logic [7:0] adr;
      if ($urandom_range(1, 0) == 1) adr = hot_adr[$urandom_range(21, 0)];
      else adr = 8'($urandom);
      rd_seed = 8'($urandom);
      status_in = $urandom;
      do_access(1'($urandom), adr, 8'($urandom), int'($urandom_range(3, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
